// File: rtl/tap_sequencer.sv
// Tap-period sequencer: times button presses in timepulse units, optionally averages the last
// four intervals (TAP_SEQ_AVG_EN) and owns the per2bpm request/response handshake.
module tap_sequencer #(
  parameter int unsigned CLK_PER_NS   = 40,
  parameter int unsigned TP_CYCLE     = 5120,
  parameter int unsigned BTN_PER_MAX  =
    32'((64'd60_000_000_000 / 64'(CLK_PER_NS)) / 64'(TP_CYCLE)),
  parameter int unsigned BTN_PER_SIZE = $clog2(BTN_PER_MAX + 1),
  parameter int unsigned BPM_SIZE     = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    tp_i,
  input  logic                    btn_i,
  output logic [BTN_PER_SIZE-1:0] btn_per_o,
  output logic                    btn_per_valid_o,
  input  logic [BPM_SIZE-1:0]     bpm_i,
  input  logic                    bpm_valid_i,
  output logic [BPM_SIZE-1:0]     bpm_o,
  output logic                    bpm_update_o
);

  localparam logic [BTN_PER_SIZE-1:0] PerMax = BTN_PER_SIZE'(BTN_PER_MAX);

  typedef enum logic {MIdle, MCount} m_state_e;
  typedef enum logic [1:0] {DIdle, DReq, DWait} d_state_e;

  m_state_e m_state_q, m_state_d;
  d_state_e d_state_q, d_state_d;

  logic                    btn_q;
  logic [BTN_PER_SIZE-1:0] cnt_q, cnt_d;
  logic                    pending_q, pending_d;
  logic [BTN_PER_SIZE-1:0] btn_per_q, btn_per_d;
  logic [BPM_SIZE-1:0]     bpm_q, bpm_d;
  logic                    bpm_update_q;

  logic                    press;
  logic                    sample;
  logic                    timeout;
  logic                    load;
  logic                    accept;
  logic [BTN_PER_SIZE-1:0] avg;

  assign press = btn_i & ~btn_q;

  // ---------------------------------------------------------------------------------------------
  // Measurement FSM
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_state_q <= MIdle;
      d_state_q <= DIdle;
    end else begin
      m_state_q <= m_state_d;
      d_state_q <= d_state_d;
    end
  end

  always_comb begin
    m_state_d = m_state_q;
    unique case (m_state_q)
      MIdle:  if (press) m_state_d = MCount;
      MCount: if (!press && cnt_q == PerMax) m_state_d = MIdle;
      default: m_state_d = MIdle;
    endcase
  end

  // A press wins over a simultaneous timeout: the saturated count becomes the sample.
  always_comb begin
    sample  = 1'b0;
    timeout = 1'b0;
    unique case (m_state_q)
      MIdle:  ;
      MCount: begin
        sample  = press;
        timeout = ~press & (cnt_q == PerMax);
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (press) begin
      cnt_d = '0;
    end else if (tp_i && cnt_q != PerMax) begin
      cnt_d = cnt_q + BTN_PER_SIZE'(1);
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Interval history
  // ---------------------------------------------------------------------------------------------
`ifdef TAP_SEQ_AVG_EN
  logic [BTN_PER_SIZE-1:0] hist_q [4];
  logic [BTN_PER_SIZE-1:0] hist_d [4];
  logic [BTN_PER_SIZE+1:0] sum_q, sum_d;
  logic                    hist_valid_q, hist_valid_d;

  always_comb begin
    hist_d       = hist_q;
    sum_d        = sum_q;
    hist_valid_d = hist_valid_q;
    if (sample) begin
      if (!hist_valid_q) begin
        // First sample of a run seeds every slot so the average is meaningful at once.
        for (int i = 0; i < 4; i++) begin
          hist_d[i] = cnt_q;
        end
        sum_d        = {cnt_q, 2'b00};
        hist_valid_d = 1'b1;
      end else begin
        hist_d[0] = cnt_q;
        hist_d[1] = hist_q[0];
        hist_d[2] = hist_q[1];
        hist_d[3] = hist_q[2];
        sum_d     = sum_q - {2'b00, hist_q[3]} + {2'b00, cnt_q};
      end
    end else if (timeout) begin
      hist_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 4; i++) begin
        hist_q[i] <= '0;
      end
      sum_q        <= '0;
      hist_valid_q <= 1'b0;
    end else begin
      hist_q       <= hist_d;
      sum_q        <= sum_d;
      hist_valid_q <= hist_valid_d;
    end
  end

  assign avg = BTN_PER_SIZE'(sum_q >> 2);
`else
  logic [BTN_PER_SIZE-1:0] last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (sample) begin
      last_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= '0;
    end else begin
      last_q <= last_d;
    end
  end

  assign avg = last_q;
`endif

  // ---------------------------------------------------------------------------------------------
  // Divider handshake FSM
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    d_state_d = d_state_q;
    unique case (d_state_q)
      DIdle:   if (pending_q) d_state_d = DReq;
      DReq:    d_state_d = DWait;
      DWait:   if (bpm_valid_i) d_state_d = DIdle;
      default: d_state_d = DIdle;
    endcase
  end

  always_comb begin
    load            = 1'b0;
    btn_per_valid_o = 1'b0;
    accept          = 1'b0;
    unique case (d_state_q)
      DIdle:   load = pending_q;
      DReq:    btn_per_valid_o = 1'b1;
      DWait:   accept = bpm_valid_i;
      default: ;
    endcase
  end

  // A fresh sample keeps the request pending even when the previous one is loaded this cycle.
  always_comb begin
    pending_d = pending_q;
    if (sample) begin
      pending_d = 1'b1;
    end else if (load || timeout) begin
      pending_d = 1'b0;
    end
  end

  always_comb begin
    btn_per_d = load ? avg : btn_per_q;
    bpm_d     = accept ? bpm_i : bpm_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      btn_q        <= 1'b0;
      cnt_q        <= '0;
      pending_q    <= 1'b0;
      btn_per_q    <= '0;
      bpm_q        <= '0;
      bpm_update_q <= 1'b0;
    end else begin
      btn_q        <= btn_i;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      btn_per_q    <= btn_per_d;
      bpm_q        <= bpm_d;
      bpm_update_q <= accept;
    end
  end

  assign btn_per_o    = btn_per_q;
  assign bpm_o        = bpm_q;
  assign bpm_update_o = bpm_update_q;

endmodule

// File: doc/tap_sequencer.md
# tap_sequencer

Sequences the tap-period-to-BPM datapath. It measures the interval between debounced button presses in timepulse units and keeps a 4-sample moving average of those intervals. It issues one divide request per press to the per2bpm divider and latches each returned BPM value for the display path. It sits between the debouncer/timepulse generator and per2bpm, and owns the divider's request handshake.

## Interface

- CLK_PER_NS, 40, system clock period in ns.
- TP_CYCLE, 5120, clocks per timepulse.
- BTN_PER_MAX, derived: (60_000_000_000/CLK_PER_NS)/TP_CYCLE (292968 at defaults).
- BTN_PER_SIZE, derived: $clog2(BTN_PER_MAX+1) (19 at defaults).
- BPM_SIZE, 8, BPM width.

Ports:

- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-high.
- tp_i  in  1  timepulse strobe, one cycle high per tick.
- btn_i  in  1  debounced button level, synchronous to clk_i.
- btn_per_o  out  BTN_PER_SIZE  period sent to the divider; registered.
- btn_per_valid_o  out  1  one-cycle divide request.
- bpm_i  in  BPM_SIZE  divider result.
- bpm_valid_i  in  1  one-cycle divider-done strobe.
- bpm_o  out  BPM_SIZE  last latched BPM value.
- bpm_update_o  out  1  one-cycle pulse when bpm_o changes.

## Operation

- Press = rising edge of btn_i, detected against a registered copy (btn_q).
- Period counter:
  - Increments on tp_i and saturates at BTN_PER_MAX.
  - Cleared to 0 on a press. A tp_i in the same cycle as a press is dropped.
- Measurement FSM, states M_IDLE and M_COUNT:
  - M_IDLE + press: clear counter, go to M_COUNT. No sample is taken and no request is issued.
  - M_COUNT + press: the counter value becomes the sample. Push it into the history, raise the request-pending flag, stay in M_COUNT.
  - M_COUNT + counter == BTN_PER_MAX (timeout): invalidate the history, go to M_IDLE. bpm_o holds its value.
- History: 4 entries of BTN_PER_SIZE bits.
  - The first sample after M_IDLE is written to all 4 entries.
  - Later samples shift in and discard the oldest entry.
  - The running sum is BTN_PER_SIZE+2 bits, never truncated. avg = sum[BTN_PER_SIZE+1:2], i.e. truncating division by 4.
- Divider FSM, states D_IDLE, D_REQ, D_WAIT:
  - D_IDLE + pending: load btn_per_o with the current average, clear pending, go to D_REQ.
  - D_REQ: assert btn_per_valid_o for exactly one cycle, go to D_WAIT.
  - D_WAIT + bpm_valid_i: latch bpm_i into bpm_o, pulse bpm_update_o on the next cycle, go to D_IDLE.
- Presses during D_REQ or D_WAIT still update the history and set pending. Multiple presses collapse into one request that uses the newest average.
- A timeout while in D_REQ or D_WAIT lets the in-flight divide complete and latch its result. Pending is cleared.
- bpm_valid_i outside D_WAIT is ignored.
- btn_per_o never changes while in D_REQ or D_WAIT.

## Timing

- Reset values: btn_per_o=0, btn_per_valid_o=0, bpm_o=0, bpm_update_o=0. Both FSMs are idle, the counter is 0, the history is invalid, pending is 0, and btn_q=0.
- Press seen in cycle N, divider idle:
  - History and sum update at the end of cycle N.
  - btn_per_o loads at the end of cycle N+1.
  - btn_per_valid_o is high in cycle N+2.
- bpm_valid_i high in cycle K: bpm_o is updated and bpm_update_o is high in cycle K+1.
- Back-to-back: a pending request leaves D_IDLE in the cycle after D_WAIT ends.
- Reset mid-operation clears everything immediately. Any divide already in flight is not tracked after release; its bpm_valid_i is ignored, since the FSM is in D_IDLE.

## Configuration

- TAP_SEQ_AVG_EN defined: 4-entry history and moving average, as described above.
- TAP_SEQ_AVG_EN undefined: no history or sum registers. The average is the latest sample, so btn_per_o equals the last measured period. All timing is unchanged.

## Test plan

The bench instantiates a real per2bpm at default parameters. tp_i may be driven every cycle to accelerate the test.

- Reset released, no stimulus -> all outputs 0 and btn_per_valid_o never asserts.
- Presses separated by 2441 tp_i -> the first press issues no request. The second press gives btn_per_o=2441 with btn_per_valid_o in cycle N+2, followed by bpm_o=120 and bpm_update_o.
- Steady 2441 taps, then one interval of 1220 -> btn_per_o=2135 (AVG_EN) or 1220 (no AVG_EN).
- Three presses while the divider is in D_WAIT -> exactly one further request, carrying the average after the third press.
- No press for 292968 tp_i -> returns to M_IDLE and bpm_o holds 120. The next press issues no request; the following press with a 4882 interval gives btn_per_o=4882 and bpm_o=60.
- rst_i pulsed during D_WAIT -> outputs return to 0, the stray bpm_valid_i is ignored, and bpm_update_o stays 0.
